if_id_pipe: RTL and testbench
=============================

# if_id_pipe

Parametrised IF/ID pipeline register with a valid/ready handshake, a synchronous flush and an optional two-entry skid buffer. It sits between the fetch stage and the decode stage of the MIPS32 core. It lets decode stall fetch without a combinational ready path, and lets branch/exception logic squash the instruction in flight. Invalid slots present a NOP so legacy decode logic that ignores `id_valid` stays correct.

## Interface
- `ADDR_W`, default 32: PC width.
- `INST_W`, default 32: instruction width.
- `NOP_INST`, default 32'h0000_0000: instruction word driven on `id_inst` when no valid instruction is held.
- `SKID_EN`, default 1:
  - 1 gives a two-entry skid buffer with a registered `if_ready`.
  - 0 gives a single register with a combinational `if_ready`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  squash all held entries (branch mispredict / exception).
- `if_valid`  in  1  fetch presents an instruction.
- `if_ready`  out  1  register can accept this cycle.
- `if_pc`  in  ADDR_W  PC of the fetched instruction.
- `if_inst`  in  INST_W  fetched instruction.
- `id_valid`  out  1  decode-side entry valid.
- `id_ready`  in  1  decode consumes this cycle.
- `id_pc`  out  ADDR_W  PC of the head entry.
- `id_inst`  out  INST_W  instruction of the head entry.

## Operation
- Accept means `if_valid && if_ready`; consume means `id_valid && id_ready`.
- Storage: main slot M (drives the `id_*` outputs) and skid slot S (only when `SKID_EN=1`).
- State machine (`SKID_EN=1`), where state is the number of valid slots:
  - EMPTY:
    - accept: M <= in, go to FULL.
    - otherwise: stay.
  - FULL:
    - accept & consume: M <= in, stay FULL.
    - accept only: S <= in, go to SKID.
    - consume only: go to EMPTY.
    - neither: hold.
  - SKID:
    - consume: M <= S, go to FULL.
    - otherwise: hold.
    - No accept is possible because `if_ready=0`.
- `if_ready` (`SKID_EN=1`) is registered and equals (next state != SKID).
- `SKID_EN=0` mode:
  - M only, no S.
  - `if_ready = !id_valid || id_ready` (combinational).
  - Accept loads M; consume without accept clears `id_valid`.
- Program order is always preserved. No entry is ever dropped or duplicated except by `flush`/`rst`.
- `id_valid=0` forces `id_pc=0` and `id_inst=NOP_INST`. Output data registers are loaded with these values whenever M becomes empty.
- Priority: `rst` > `flush` > handshake.
- Flush behaviour:
  - Next state is EMPTY; `id_valid=0`.
  - `id_pc=0` and `id_inst=NOP_INST` next cycle.
  - Any instruction accepted in the flush cycle is discarded.
  - A consume in the flush cycle is still a legal transfer; decode owns that instruction.
- Reset values:
  - `id_valid=0`, `id_pc=0`, `id_inst=NOP_INST`.
  - `if_ready=1` (`SKID_EN=1`); state EMPTY; S invalid.
  - Handshakes during a `rst` cycle are ignored.

## Timing
- Latency: instruction accepted at edge N is visible on `id_*` with `id_valid=1` after edge N (cycle N+1).
- Throughput: one instruction per cycle while `id_ready=1`, in both modes.
- `SKID_EN=1` backpressure:
  - When `id_ready` drops, one further instruction is absorbed into S.
  - `if_ready` falls the cycle after.
  - No input-to-output combinational path exists.
- After `id_ready` returns in SKID, M <= S at that edge, and `if_ready=1` in the next cycle.
- `flush` held for multiple cycles keeps the block EMPTY.
  - `if_ready` stays 1.
  - Accepts during the flush are discarded.
- A mid-stream `rst` behaves like `flush` and also restores `if_ready=1`.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` with `if_valid=1`, `if_pc=32'h100`.
  - Required: `id_valid=0`, `id_pc=0`, `id_inst=NOP_INST`, `if_ready=1`; nothing is captured.
- **Streaming:**
  - Stimulus: `id_ready=1`; PCs 0x0, 0x4, 0x8 with insts A, B, C on consecutive cycles.
  - Required: `id_*` show (0x0,A), (0x4,B), (0x8,C) one cycle later each, `id_valid=1` throughout.
- **Backpressure (`SKID_EN=1`):**
  - Stimulus: in FULL with (0x0,A), drop `id_ready`; offer (0x4,B), then (0x8,C).
  - Required:
    - B is accepted into S and `if_ready` goes 0; C is held by fetch.
    - On `id_ready=1`: A consumed, then B, then C, with no loss or duplication.
- **Flush in SKID:**
  - Stimulus: A in M, B in S; pulse `flush` with `if_valid=1` (0xC,D).
  - Required: next cycle `id_valid=0`, `id_inst=NOP_INST`, `if_ready=1`; D is never output.
- **Simultaneous accept and consume in FULL:**
  - Stimulus: A in M; accept (0x4,B) while A is consumed.
  - Required: next cycle M=(0x4,B), state FULL, `if_ready=1`.
- **`SKID_EN=0`:**
  - Stimulus: `id_valid=1`, `id_ready=0`.
  - Required: `if_ready=0` in the same cycle. Raising `id_ready` gives `if_ready=1` combinationally, and the new instruction loads at that edge.

Source files
------------

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer. Empty slots present PC 0 and NOP_INST.
module if_id_pipe #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0000),
  parameter bit                SKID_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
);

  if (SKID_EN) begin : g_skid
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] m_pc_q, m_pc_d, s_pc_q, s_pc_d;
    logic [INST_W-1:0] m_inst_q, m_inst_d, s_inst_q, s_inst_d;
    logic              valid_q, rdy_q;
    logic              accept, consume;

    assign accept  = if_valid && rdy_q;
    assign consume = valid_q && id_ready;

    // State, slot and registered-handshake update
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= EMPTY;
        m_pc_q   <= '0;
        m_inst_q <= NOP_INST;
        s_pc_q   <= '0;
        s_inst_q <= NOP_INST;
        valid_q  <= 1'b0;
        rdy_q    <= 1'b1;
      end else begin
        state_q  <= state_d;
        m_pc_q   <= m_pc_d;
        m_inst_q <= m_inst_d;
        s_pc_q   <= s_pc_d;
        s_inst_q <= s_inst_d;
        valid_q  <= (state_d != EMPTY);
        rdy_q    <= (state_d != SKID);
      end
    end

    // Next state and slot contents; flush overrides the handshake
    always_comb begin
      state_d  = state_q;
      m_pc_d   = m_pc_q;
      m_inst_d = m_inst_q;
      s_pc_d   = s_pc_q;
      s_inst_d = s_inst_q;
      if (flush) begin
        state_d  = EMPTY;
        m_pc_d   = '0;
        m_inst_d = NOP_INST;
      end else begin
        case (state_q)
          EMPTY: begin
            if (accept) begin
              m_pc_d   = if_pc;
              m_inst_d = if_inst;
              state_d  = FULL;
            end
          end
          FULL: begin
            if (accept && consume) begin
              m_pc_d   = if_pc;
              m_inst_d = if_inst;
            end else if (accept) begin
              s_pc_d   = if_pc;
              s_inst_d = if_inst;
              state_d  = SKID;
            end else if (consume) begin
              m_pc_d   = '0;
              m_inst_d = NOP_INST;
              state_d  = EMPTY;
            end
          end
          SKID: begin
            if (consume) begin
              m_pc_d   = s_pc_q;
              m_inst_d = s_inst_q;
              state_d  = FULL;
            end
          end
          default: begin
            state_d  = EMPTY;
            m_pc_d   = '0;
            m_inst_d = NOP_INST;
          end
        endcase
      end
    end

    assign if_ready = rdy_q;
    assign id_valid = valid_q;
    assign id_pc    = m_pc_q;
    assign id_inst  = m_inst_q;

  end else begin : g_single
    logic [ADDR_W-1:0] m_pc_q;
    logic [INST_W-1:0] m_inst_q;
    logic              valid_q;
    logic              accept, consume;

    assign if_ready = !valid_q || id_ready;
    assign accept   = if_valid && if_ready;
    assign consume  = valid_q && id_ready;

    // Single slot: load on accept, drain to NOP on consume or flush
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        valid_q  <= 1'b0;
        m_pc_q   <= '0;
        m_inst_q <= NOP_INST;
      end else if (accept) begin
        valid_q  <= 1'b1;
        m_pc_q   <= if_pc;
        m_inst_q <= if_inst;
      end else if (consume) begin
        valid_q  <= 1'b0;
        m_pc_q   <= '0;
        m_inst_q <= NOP_INST;
      end
    end

    assign id_valid = valid_q;
    assign id_pc    = m_pc_q;
    assign id_inst  = m_inst_q;
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Scoreboard bench for if_id_pipe: u0 with skid buffer, u1 without.
module tb_if_id_pipe;

  localparam logic [31:0] NOP = 32'h1357_9BDF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_flush, a_if_valid, a_if_ready, a_id_valid, a_id_ready;
  logic [31:0] a_if_pc, a_if_inst, a_id_pc, a_id_inst;
  logic        b_rst, b_flush, b_if_valid, b_if_ready, b_id_valid, b_id_ready;
  logic [31:0] b_if_pc, b_if_inst, b_id_pc, b_id_inst;

  if_id_pipe #(.ADDR_W(32), .INST_W(32), .NOP_INST(NOP), .SKID_EN(1'b1)) u0 (
    .clk(clk), .rst(a_rst), .flush(a_flush), .if_valid(a_if_valid),
    .if_ready(a_if_ready), .if_pc(a_if_pc), .if_inst(a_if_inst),
    .id_valid(a_id_valid), .id_ready(a_id_ready), .id_pc(a_id_pc), .id_inst(a_id_inst));

  if_id_pipe #(.ADDR_W(32), .INST_W(32), .NOP_INST(NOP), .SKID_EN(1'b0)) u1 (
    .clk(clk), .rst(b_rst), .flush(b_flush), .if_valid(b_if_valid),
    .if_ready(b_if_ready), .if_pc(b_if_pc), .if_inst(b_if_inst),
    .id_valid(b_id_valid), .id_ready(b_id_ready), .id_pc(b_id_pc), .id_inst(b_id_inst));

  int total = 0;
  int bad   = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic mon0 = 1'b0;
  logic mon1 = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every consume pops the oldest expected entry; idle slots must show NOP
  always @(negedge clk) begin
    logic [63:0] e;
    if (mon0) begin
      if (a_id_valid) begin
        if (a_id_ready) begin
          if (q0.size() == 0) chk("u0 unexpected output pc", a_id_pc, 32'hFFFF_FFFF);
          else begin
            e = q0.pop_front();
            chk("u0 pc", a_id_pc, e[63:32]);
            chk("u0 inst", a_id_inst, e[31:0]);
          end
        end
      end else begin
        chk("u0 idle pc", a_id_pc, 32'h0);
        chk("u0 idle inst", a_id_inst, NOP);
      end
    end
    if (mon1) begin
      if (b_id_valid) begin
        if (b_id_ready) begin
          if (q1.size() == 0) chk("u1 unexpected output pc", b_id_pc, 32'hFFFF_FFFF);
          else begin
            e = q1.pop_front();
            chk("u1 pc", b_id_pc, e[63:32]);
            chk("u1 inst", b_id_inst, e[31:0]);
          end
        end
      end else begin
        chk("u1 idle pc", b_id_pc, 32'h0);
        chk("u1 idle inst", b_id_inst, NOP);
      end
    end
  end

  // One cycle of stimulus; checks if_ready mid-cycle and records the expected output
  task automatic send(input int sel, input logic [31:0] pc, input logic [31:0] inst,
                      input logic v, input logic rdy, input logic fl,
                      input logic exp_rdy, input logic push);
    if (sel == 0) begin
      a_if_pc = pc; a_if_inst = inst; a_if_valid = v; a_id_ready = rdy; a_flush = fl;
    end else begin
      b_if_pc = pc; b_if_inst = inst; b_if_valid = v; b_id_ready = rdy; b_flush = fl;
    end
    @(negedge clk);
    if (sel == 0) chk("u0 if_ready", {31'b0, a_if_ready}, {31'b0, exp_rdy});
    else          chk("u1 if_ready", {31'b0, b_if_ready}, {31'b0, exp_rdy});
    if (push) begin
      if (sel == 0) q0.push_back({pc, inst});
      else          q1.push_back({pc, inst});
    end
    @(posedge clk); #1;
  endtask

  // Idle cycle with no offer; optionally require the empty state
  task automatic idle(input int sel, input logic rdy, input logic chk_empty);
    if (sel == 0) begin a_if_valid = 1'b0; a_id_ready = rdy; a_flush = 1'b0; end
    else          begin b_if_valid = 1'b0; b_id_ready = rdy; b_flush = 1'b0; end
    @(negedge clk);
    if (chk_empty) begin
      if (sel == 0) begin
        chk("u0 empty id_valid", {31'b0, a_id_valid}, 32'h0);
        chk("u0 empty if_ready", {31'b0, a_if_ready}, 32'h1);
      end else begin
        chk("u1 empty id_valid", {31'b0, b_id_valid}, 32'h0);
        chk("u1 empty if_ready", {31'b0, b_if_ready}, 32'h1);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_if_valid = 1'b1; a_if_pc = 32'h100;
    a_if_inst = 32'hAAAA_0001; a_id_ready = 1'b1;
    b_rst = 1'b1; b_flush = 1'b0; b_if_valid = 1'b0; b_if_pc = 32'h0;
    b_if_inst = 32'h0; b_id_ready = 1'b0;

    // ---- u0: reset with a pending offer ----
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("u0 rst id_valid", {31'b0, a_id_valid}, 32'h0);
    chk("u0 rst id_pc", a_id_pc, 32'h0);
    chk("u0 rst id_inst", a_id_inst, NOP);
    chk("u0 rst if_ready", {31'b0, a_if_ready}, 32'h1);
    @(posedge clk); #1;
    a_rst = 1'b0; a_if_valid = 1'b0;
    @(negedge clk);
    chk("u0 post-rst id_valid", {31'b0, a_id_valid}, 32'h0);
    mon0 = 1'b1;
    @(posedge clk); #1;

    // Streaming: A, B, C back to back
    send(0, 32'h0, 32'hA000_000A, 1, 1, 0, 1, 1);
    chk("u0 latency id_valid", {31'b0, a_id_valid}, 32'h1);
    send(0, 32'h4, 32'hB000_000B, 1, 1, 0, 1, 1);
    chk("u0 accept+consume id_pc", a_id_pc, 32'h4);
    send(0, 32'h8, 32'hC000_000C, 1, 1, 0, 1, 1);
    idle(0, 1, 0);
    idle(0, 1, 1);

    // Backpressure: second entry goes to skid, third held by fetch
    send(0, 32'h20, 32'h1111_0001, 1, 0, 0, 1, 1);
    send(0, 32'h24, 32'h1111_0002, 1, 0, 0, 1, 1);
    send(0, 32'h28, 32'h1111_0003, 1, 0, 0, 0, 0);
    chk("u0 skid holds head pc", a_id_pc, 32'h20);
    send(0, 32'h28, 32'h1111_0003, 1, 0, 0, 0, 0);
    send(0, 32'h28, 32'h1111_0003, 1, 1, 0, 0, 0);
    send(0, 32'h28, 32'h1111_0003, 1, 1, 0, 1, 1);
    idle(0, 1, 0);
    idle(0, 1, 1);

    // Flush while in SKID with an offer present
    send(0, 32'h30, 32'h2222_0001, 1, 0, 0, 1, 0);
    send(0, 32'h34, 32'h2222_0002, 1, 0, 0, 1, 0);
    send(0, 32'h0C, 32'hDDDD_000D, 1, 0, 1, 0, 0);
    idle(0, 0, 1);

    // Multi-cycle flush discards accepts
    send(0, 32'h40, 32'h3333_0001, 1, 1, 1, 1, 0);
    send(0, 32'h44, 32'h3333_0002, 1, 1, 1, 1, 0);
    idle(0, 1, 1);

    // Consume during a flush cycle is a legal transfer
    send(0, 32'h50, 32'h4444_0001, 1, 0, 0, 1, 1);
    send(0, 32'h54, 32'h4444_0002, 1, 1, 1, 1, 0);
    idle(0, 1, 1);

    // Mid-stream reset from SKID
    send(0, 32'h60, 32'h5555_0001, 1, 0, 0, 1, 0);
    send(0, 32'h64, 32'h5555_0002, 1, 0, 0, 1, 0);
    a_rst = 1'b1;
    send(0, 32'h68, 32'h5555_0003, 1, 0, 0, 0, 0);
    a_rst = 1'b0;
    idle(0, 0, 1);
    chk("u0 queue drained", q0.size(), 32'h0);
    mon0 = 1'b0;

    // ---- u1: single register, combinational if_ready ----
    b_if_valid = 1'b1; b_if_pc = 32'h100; b_if_inst = 32'hAAAA_0001;
    @(posedge clk); #1;
    @(negedge clk);
    chk("u1 rst id_valid", {31'b0, b_id_valid}, 32'h0);
    chk("u1 rst id_pc", b_id_pc, 32'h0);
    chk("u1 rst id_inst", b_id_inst, NOP);
    @(posedge clk); #1;
    b_rst = 1'b0; b_if_valid = 1'b0;
    mon1 = 1'b1;
    idle(1, 1, 1);

    send(1, 32'h0, 32'hA000_000A, 1, 1, 0, 1, 1);
    send(1, 32'h4, 32'hB000_000B, 1, 1, 0, 1, 1);
    send(1, 32'h8, 32'hC000_000C, 1, 1, 0, 1, 1);
    idle(1, 1, 0);
    idle(1, 1, 1);

    // Stall: if_ready follows id_ready in the same cycle
    send(1, 32'h20, 32'h6666_0001, 1, 0, 0, 1, 1);
    send(1, 32'h24, 32'h6666_0002, 1, 0, 0, 0, 0);
    send(1, 32'h24, 32'h6666_0002, 1, 1, 0, 1, 1);
    chk("u1 load on release pc", b_id_pc, 32'h24);
    idle(1, 1, 0);
    idle(1, 1, 1);

    // Flush squashes the held entry
    send(1, 32'h30, 32'h7777_0001, 1, 0, 0, 1, 0);
    send(1, 32'h34, 32'h7777_0002, 1, 0, 1, 0, 0);
    idle(1, 0, 1);
    chk("u1 queue drained", q1.size(), 32'h0);
    mon1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
